// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM state type, guard-bit width, gain constant and
// saturation limit. Used by the vectoring unit and the downstream rotation unit.
package cordic_pkg;

    typedef enum logic [1:0] {IDLE, ITER, POST} state_t;

    // Headroom above the operand word for the sqrt(2) * 1.647 magnitude growth
    localparam int GUARD_BITS = 2;

    // K = round(0.607253 * 2^frac), the inverse of the accumulated CORDIC gain
    function automatic int gain_k(int frac);
        longint num;
        num = 64'sd607253 <<< frac;
        return 32'((num + 64'sd500000) / 64'sd1000000);
    endfunction

    // Largest positive value of a signed w-bit word
    function automatic longint sat_limit(int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/cordic_vectoring_unit_if.sv
// Start/done handshake and operand/result bus of the CORDIC vectoring unit.
interface cordic_vectoring_unit_if #(
    parameter int W          = 17,
    parameter int ITERATIONS = 12
);
    logic                    start;
    logic signed [W-1:0]     x_in;
    logic signed [W-1:0]     y_in;
    logic                    busy;
    logic                    done;
    logic signed [W-1:0]     mag_out;
    logic                    flip_out;
    logic [ITERATIONS-1:0]   dir_out;

    modport master (
        output start, x_in, y_in,
        input  busy, done, mag_out, flip_out, dir_out
    );

    modport slave (
        input  start, x_in, y_in,
        output busy, done, mag_out, flip_out, dir_out
    );
endinterface

// File: rtl/cordic_micro_rotation.sv
// One combinational CORDIC micro-rotation: x/y shift-add for step i and direction
// sigma (1 = +1, 0 = -1). Shifts are arithmetic, truncating toward -inf.
module cordic_micro_rotation #(
    parameter int XW = 19,
    parameter int SW = 4
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic [SW-1:0]        i,
    input  logic                 sigma,
    output logic signed [XW-1:0] x_next,
    output logic signed [XW-1:0] y_next
);
    logic signed [XW-1:0] xs;
    logic signed [XW-1:0] ys;

    // Shift-add; sigma=+1 drives y toward zero from above
    always_comb begin
        xs = x >>> i;
        ys = y >>> i;
        if (sigma) begin
            x_next = x + ys;
            y_next = y - xs;
        end else begin
            x_next = x - ys;
            y_next = y + xs;
        end
    end
endmodule

// File: rtl/cordic_vectoring_unit.sv
// Iterative vectoring-mode CORDIC: magnitude of (x_in, y_in) plus the rotation
// direction of every micro-step. One micro-rotation per clock, latency ITERATIONS+1.
// Optional build macro CORDIC_GAIN_COMP_EN: scale the magnitude by K in POST.
module cordic_vectoring_unit
    import cordic_pkg::*;
#(
    parameter int INT_LENGTH  = 5,
    parameter int FRAC_LENGTH = 12,
    parameter int ITERATIONS  = 12
) (
    input logic                    clk,
    input logic                    rst,
    cordic_vectoring_unit_if.slave bus
);
    localparam int W  = INT_LENGTH + FRAC_LENGTH;
    localparam int XW = W + GUARD_BITS;
    localparam int CW = $clog2(ITERATIONS + 1);
    localparam int PW = XW + FRAC_LENGTH + 1;
    localparam logic signed [PW-1:0] MAG_MAX = PW'(sat_limit(W));
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [PW-1:0] GAIN_K = PW'(gain_k(FRAC_LENGTH));
`endif

    state_t                state_q;
    logic signed [XW-1:0]  x_q, y_q;
    logic [CW-1:0]         i_q;
    logic [ITERATIONS-1:0] dir_q;
    logic                  flip_q;
    logic                  busy_q, done_q, flip_out_q;
    logic signed [W-1:0]   mag_out_q;
    logic [ITERATIONS-1:0] dir_out_q;

    logic signed [XW-1:0]  x_ext, y_ext, x_rot, y_rot;
    logic                  sigma;
    logic signed [PW-1:0]  mag_full;
    logic signed [W-1:0]   mag_sat;
`ifdef CORDIC_GAIN_COMP_EN
    logic signed [PW-1:0]  prod;
`endif

    // Operands widened before a possible negation so -2^(W-1) cannot overflow
    assign x_ext = {{GUARD_BITS{bus.x_in[W-1]}}, bus.x_in};
    assign y_ext = {{GUARD_BITS{bus.y_in[W-1]}}, bus.y_in};
    assign sigma = ~y_q[XW-1];

    cordic_micro_rotation #(
        .XW (XW),
        .SW (CW)
    ) u_rot (
        .x      (x_q),
        .y      (y_q),
        .i      (i_q),
        .sigma  (sigma),
        .x_next (x_rot),
        .y_next (y_rot)
    );

    // Optional gain compensation, then clamp into [0, 2^(W-1)-1]
    always_comb begin
        mag_full = PW'(x_q);
`ifdef CORDIC_GAIN_COMP_EN
        prod     = mag_full * GAIN_K;
        mag_full = prod >>> FRAC_LENGTH;
`endif
        if (mag_full < 0) begin
            mag_sat = '0;
        end else if (mag_full > MAG_MAX) begin
            mag_sat = MAG_MAX[W-1:0];
        end else begin
            mag_sat = mag_full[W-1:0];
        end
    end

    // Control FSM with registered outputs; reset aborts any run in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            i_q        <= '0;
            dir_q      <= '0;
            flip_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flip_out_q <= 1'b0;
            mag_out_q  <= '0;
            dir_out_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // Pi pre-rotation puts the vector in the right half-plane
                        if (bus.x_in[W-1]) begin
                            x_q    <= -x_ext;
                            y_q    <= -y_ext;
                            flip_q <= 1'b1;
                        end else begin
                            x_q    <= x_ext;
                            y_q    <= y_ext;
                            flip_q <= 1'b0;
                        end
                        i_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    x_q        <= x_rot;
                    y_q        <= y_rot;
                    dir_q[i_q] <= sigma;
                    i_q        <= i_q + 1'b1;
                    if (i_q == CW'(ITERATIONS - 1)) begin
                        state_q <= POST;
                    end
                end
                POST: begin
                    mag_out_q  <= mag_sat;
                    flip_out_q <= flip_q;
                    dir_out_q  <= dir_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mag_out  = mag_out_q;
    assign bus.flip_out = flip_out_q;
    assign bus.dir_out  = dir_out_q;
endmodule

// File: tb/tb_cordic_vectoring_unit.sv
// Scoreboard bench for cordic_vectoring_unit: the driver queues the expected
// result of every accepted start, a monitor checks each done pulse against it.
module tb_cordic_vectoring_unit;
    localparam int W      = 17;
    localparam int IT     = 12;
    localparam int LAT    = IT + 1;
    localparam int PERIOD = IT + 2;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int M34 = 20480, T34 = 8;
    localparam int M12 = 12288, T12 = 8;
    localparam int M4  = 4096,  T4  = 8;
`else
    localparam int M34 = 33726, T34 = 16;
    localparam int M12 = 20235, T12 = 16;
    localparam int M4  = 6745,  T4  = 16;
`endif

    typedef struct {
        string          name;
        int             mag;
        int             tol;
        bit             flip;
        logic [IT-1:0]  dir;
        logic [IT-1:0]  dmask;
        int             done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    cordic_vectoring_unit_if #(.W(W), .ITERATIONS(IT)) bus ();

    cordic_vectoring_unit #(
        .INT_LENGTH  (5),
        .FRAC_LENGTH (12),
        .ITERATIONS  (IT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic push_exp(input string nm, input int mag, input int tol, input bit flip,
                            input logic [IT-1:0] dir, input logic [IT-1:0] dmask,
                            input int done_cyc);
        exp_t e;
        e.name = nm; e.mag = mag; e.tol = tol; e.flip = flip;
        e.dir = dir; e.dmask = dmask; e.done_cyc = done_cyc;
        sb.push_back(e);
    endtask

    // Issue one start, queue its expectation, scramble the operands afterwards
    task automatic run_one(input string nm, input int x, input int y, input int mag,
                           input int tol, input bit flip, input logic [IT-1:0] dir,
                           input logic [IT-1:0] dmask);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = W'(x);
        bus.y_in  = W'(y);
        push_exp(nm, mag, tol, flip, dir, dmask, cyc + 1 + LAT);
        @(negedge clk);
        bus.start = 1'b0;
        bus.x_in  = W'($urandom);
        bus.y_in  = W'($urandom);
        cmp({nm, "_busy"}, int'(bus.busy), 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d results pending want 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        int   got, diff;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done at cycle %0d mag=%0d want no done",
                         cyc, bus.mag_out);
            end else begin
                e    = sb.pop_front();
                got  = int'(bus.mag_out);
                diff = got - e.mag;
                if (diff < 0) diff = -diff;
                total++;
                if (diff > e.tol) begin
                    bad++;
                    $display("FAIL %s_mag: got %0d want %0d +-%0d", e.name, got, e.mag, e.tol);
                end
                cmp({e.name, "_latency"}, cyc, e.done_cyc);
                cmp({e.name, "_flip"}, int'(bus.flip_out), int'(e.flip));
                cmp({e.name, "_dir"}, int'(bus.dir_out & e.dmask), int'(e.dir & e.dmask));
                cmp({e.name, "_busy_low"}, int'(bus.busy), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int px[3];
        int py[3];
        int pm[3];
        int pt[3];
        bit pf[3];
        int idx;
        int next_acc;
        px = '{4096, -12288, 12288};
        py = '{0, 0, 16384};
        pm = '{M4, M12, M34};
        pt = '{T4, T12, T34};
        pf = '{1'b0, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("reset_busy", int'(bus.busy), 0);
        cmp("reset_done", int'(bus.done), 0);
        cmp("reset_mag", int'(bus.mag_out), 0);
        cmp("reset_flip", int'(bus.flip_out), 0);
        cmp("reset_dir", int'(bus.dir_out), 0);

        // Zero vector: every step sees y>=0
        run_one("zero", 0, 0, 0, 0, 1'b0, 12'hFFF, 12'hFFF);
        drain(40);
        run_one("x3y4", 12288, 16384, M34, T34, 1'b0, 12'h001, 12'h001);
        drain(40);
        run_one("neg_x", -12288, 0, M12, T12, 1'b1, 12'h001, 12'h001);
        drain(40);
        run_one("sat", 65000, 65000, 65535, 0, 1'b0, 12'h001, 12'h001);
        drain(40);

        // Abort a run with reset: no done may follow and outputs clear
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = W'(12288);
        bus.y_in  = W'(16384);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        cmp("abort_busy", int'(bus.busy), 0);
        cmp("abort_mag", int'(bus.mag_out), 0);
        cmp("abort_dir", int'(bus.dir_out), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run_one("after_abort", 4096, 0, M4, T4, 1'b0, 12'h001, 12'h001);
        drain(40);

        // Start held high; operands rotate every cycle so each capture is distinct
        @(negedge clk);
        next_acc = cyc + 1;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            idx       = (cyc + 1) % 3;
            bus.start = 1'b1;
            bus.x_in  = W'(px[idx]);
            bus.y_in  = W'(py[idx]);
            if (cyc + 1 == next_acc) begin
                push_exp($sformatf("held%0d", idx), pm[idx], pt[idx], pf[idx],
                         12'h001, 12'h001, next_acc + LAT);
                next_acc += PERIOD;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        drain(60);
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
